// File: rtl/log_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : log_capture_ctrl
// Purpose  : Sequencer for the BRAM sample logger. Arms capture of DSP Tx
//            filter samples, waits for the memory-full flag, then walks every
//            log address and presents each word on a valid/ready stream.
// Ports    : clk                  system clock
//            i_rstn               asynchronous active-low reset
//            i_start              pulse: start (or re-arm) capture
//            i_dump               pulse: start readout, honoured only in FULL
//            i_abort              return to IDLE from any state
//            i_mem_full           MEMLog full flag
//            i_data_log_from_mem  MEMLog read data (2*BRAM_DATA_WIDTH)
//            o_run_log            MEMLog capture enable
//            o_read_log           MEMLog read mode
//            o_addr_log_to_mem    MEMLog read address
//            o_data/o_valid       stream word and valid
//            i_ready              stream ready
//            o_busy               controller not idle
//            o_done               one-cycle pulse at end of dump
//            o_timeout            sticky capture-timeout flag
//            o_state              encoded state for VIO/LED debug
// Options  : LOGCTRL_TIMEOUT_EN   when defined, CAPTURE is bounded by a
//                                 25-bit timer of TIMEOUT_CYCLES cycles
// Revision : 1.0  initial release
// ============================================================================
module log_capture_ctrl #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int LAST_ADDR       = 2**BRAM_ADDR_WIDTH - 1,
    parameter int RD_LAT          = 1,
    parameter int TIMEOUT_CYCLES  = 2**24
) (
    input  logic                         clk,
    input  logic                         i_rstn,
    input  logic                         i_start,
    input  logic                         i_dump,
    input  logic                         i_abort,
    input  logic                         i_mem_full,
    input  logic [2*BRAM_DATA_WIDTH-1:0] i_data_log_from_mem,
    output logic                         o_run_log,
    output logic                         o_read_log,
    output logic [BRAM_ADDR_WIDTH-1:0]   o_addr_log_to_mem,
    output logic [2*BRAM_DATA_WIDTH-1:0] o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_timeout,
    output logic [2:0]                   o_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_FULL    = 3'd2,
        S_FETCH   = 3'd3,
        S_SEND    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [BRAM_ADDR_WIDTH-1:0] C_LAST_ADDR = BRAM_ADDR_WIDTH'(LAST_ADDR);
    localparam logic [BRAM_ADDR_WIDTH-1:0] C_ADDR_ONE  = BRAM_ADDR_WIDTH'(1);
    localparam logic [2:0]                 C_LAT_LAST  = 3'(RD_LAT - 1);

    // Elaboration-time parameter sanity checks
    generate
        if (RD_LAT < 1 || RD_LAT > 7) begin : g_chk_rd_lat
            $error("log_capture_ctrl: RD_LAT must be in 1..7");
        end
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 2**25 - 1) begin : g_chk_timeout
            $error("log_capture_ctrl: TIMEOUT_CYCLES must fit the 25-bit timer");
        end
        if (LAST_ADDR < 0 || LAST_ADDR >= 2**BRAM_ADDR_WIDTH) begin : g_chk_last_addr
            $error("log_capture_ctrl: LAST_ADDR must be below 2**BRAM_ADDR_WIDTH");
        end
    endgenerate

    state_t                         state_q, state_d;
    logic                           run_q, run_d;
    logic                           read_q, read_d;
    logic                           valid_q, valid_d;
    logic                           done_q, done_d;
    logic                           busy_q, busy_d;
    logic                           tmo_q, tmo_d;
    logic [BRAM_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [2*BRAM_DATA_WIDTH-1:0]   data_q, data_d;
    logic [2:0]                     lat_q, lat_d;
    logic                           w_tmo_hit;

`ifdef LOGCTRL_TIMEOUT_EN
    localparam logic [24:0] C_TMO_LAST = 25'(TIMEOUT_CYCLES - 1);
    logic [24:0] tmo_cnt_q, tmo_cnt_d;

    // Counts cycles spent in CAPTURE; restarts from zero on every entry.
    assign w_tmo_hit = (tmo_cnt_q == C_TMO_LAST);

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == S_CAPTURE && state_d == S_CAPTURE) begin
            tmo_cnt_d = tmo_cnt_q + 25'd1;
        end
    end

    always_ff @(posedge clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        read_d  = read_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        lat_d   = lat_q;
        tmo_d   = tmo_q;

        if (i_abort) begin
            // Abort outranks everything; the timeout flag deliberately survives.
            state_d = S_IDLE;
            run_d   = 1'b0;
            read_d  = 1'b0;
            valid_d = 1'b0;
            addr_d  = '0;
            lat_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d = S_CAPTURE;
                        run_d   = 1'b1;
                        tmo_d   = 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (i_mem_full) begin
                        state_d = S_FULL;
                        run_d   = 1'b0;
                    end else if (w_tmo_hit) begin
                        state_d = S_IDLE;
                        run_d   = 1'b0;
                        tmo_d   = 1'b1;
                    end
                end
                S_FULL: begin
                    if (i_start) begin
                        state_d = S_CAPTURE;
                        run_d   = 1'b1;
                        tmo_d   = 1'b0;
                    end else if (i_dump) begin
                        state_d = S_FETCH;
                        addr_d  = '0;
                        read_d  = 1'b1;
                        lat_d   = '0;
                    end
                end
                S_FETCH: begin
                    // Read data is sampled on the RD_LAT-th edge after the
                    // address was presented.
                    if (lat_q == C_LAT_LAST) begin
                        data_d  = i_data_log_from_mem;
                        valid_d = 1'b1;
                        lat_d   = '0;
                        state_d = S_SEND;
                    end else begin
                        lat_d = lat_q + 3'd1;
                    end
                end
                S_SEND: begin
                    if (valid_q && i_ready) begin
                        valid_d = 1'b0;
                        if (addr_q == C_LAST_ADDR) begin
                            addr_d  = '0;
                            read_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            addr_d  = addr_q + C_ADDR_ONE;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    run_d   = 1'b0;
                    read_d  = 1'b0;
                    valid_d = 1'b0;
                    addr_d  = '0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            read_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            read_q  <= read_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            lat_q   <= lat_d;
        end
    end

    assign o_run_log         = run_q;
    assign o_read_log        = read_q;
    assign o_addr_log_to_mem = addr_q;
    assign o_data            = data_q;
    assign o_valid           = valid_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;
    assign o_timeout         = tmo_q;
    assign o_state           = state_q;

endmodule
`default_nettype wire

// File: tb/tb_log_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_log_capture_ctrl
// Purpose  : Self-checking bench for log_capture_ctrl (AW=4, DW=8,
//            LAST_ADDR=15, RD_LAT=1, TIMEOUT_CYCLES=50). A behavioural
//            model tracks the controller mode and is compared every cycle;
//            directed sequences add literal expectations. Honours
//            LOGCTRL_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_log_capture_ctrl;

    localparam int AW   = 4;
    localparam int DW   = 8;
    localparam int LAST = 15;
    localparam int RDL  = 1;
    localparam int TMO  = 50;
`ifdef LOGCTRL_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn;
    logic            start, dump, abort, full, ready;
    logic [2*DW-1:0] mem_data;
    logic            o_run_log, o_read_log, o_valid, o_busy, o_done, o_timeout;
    logic [AW-1:0]   o_addr;
    logic [2*DW-1:0] o_data;
    logic [2:0]      o_state;

    always #5 clk = ~clk;

    // Memory contents: word at address a is a*0x0101, combinational read.
    assign mem_data = 16'(o_addr) * 16'h0101;

    log_capture_ctrl #(
        .BRAM_ADDR_WIDTH (AW),
        .BRAM_DATA_WIDTH (DW),
        .LAST_ADDR       (LAST),
        .RD_LAT          (RDL),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk                 (clk),
        .i_rstn              (rstn),
        .i_start             (start),
        .i_dump              (dump),
        .i_abort             (abort),
        .i_mem_full          (full),
        .i_data_log_from_mem (mem_data),
        .o_run_log           (o_run_log),
        .o_read_log          (o_read_log),
        .o_addr_log_to_mem   (o_addr),
        .o_data              (o_data),
        .o_valid             (o_valid),
        .i_ready             (ready),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_timeout           (o_timeout),
        .o_state             (o_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 capture, 2 full, 3 fetch, 4 send, 5 done.
    // Outputs are derived from mode: run in capture, read in fetch/send,
    // valid in send, done in done, busy whenever not idle.
    int          m_mode, m_addr, m_wait, m_cnt;
    logic        m_tmo;
    logic [15:0] m_data;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_mode <= 0; m_addr <= 0; m_wait <= 0; m_cnt <= 0;
            m_tmo  <= 1'b0; m_data <= '0;
        end else if (abort) begin
            m_mode <= 0; m_addr <= 0;
        end else if ((m_mode == 0 || m_mode == 2) && start) begin
            m_mode <= 1; m_tmo <= 1'b0; m_cnt <= 0;
        end else if (m_mode == 1) begin
            // m_cnt+1 = number of capture cycles completed at this edge
            if (full) m_mode <= 2;
            else if (TMO_ON && m_cnt + 1 == TMO) begin m_mode <= 0; m_tmo <= 1'b1; end
            else m_cnt <= m_cnt + 1;
        end else if (m_mode == 2 && dump) begin
            m_mode <= 3; m_addr <= 0; m_wait <= 0;
        end else if (m_mode == 3) begin
            if (m_wait + 1 == RDL) begin m_mode <= 4; m_data <= 16'(m_addr * 257); end
            else m_wait <= m_wait + 1;
        end else if (m_mode == 4 && ready) begin
            if (m_addr == LAST) begin m_mode <= 5; m_addr <= 0; end
            else begin m_mode <= 3; m_addr <= m_addr + 1; m_wait <= 0; end
        end else if (m_mode == 5) begin
            m_mode <= 0;
        end
    end

    // ---------------- compare process ----------------
    int          run_cycles = 0;
    int          done_cnt   = 0;
    int          cyc        = 0;
    logic [15:0] hs_q[$];
    int          hs_cyc[$];
    logic        prev_stall = 1'b0;
    logic        prev_abort = 1'b0;
    logic [15:0] prev_data  = '0;

    always @(negedge clk) begin
        cyc++;
        chk("state", 32'(o_state), 32'(m_mode));
        chk("ctrl", {o_run_log, o_read_log, o_valid, o_done, o_busy, o_timeout},
            {m_mode == 1, (m_mode == 3 || m_mode == 4), m_mode == 4, m_mode == 5, m_mode != 0, m_tmo});
        chk("addr", 32'(o_addr), 32'(m_addr));
        if (m_mode == 4) chk("data", 32'(o_data), 32'(m_data));
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (o_run_log) run_cycles++;
            if (o_done) done_cnt++;
            if (o_valid && ready) begin
                hs_q.push_back(o_data);
                hs_cyc.push_back(cyc);
            end
            if (prev_stall && !prev_abort) begin
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_data", 32'(o_data), 32'(prev_data));
            end
            prev_stall = o_valid && !ready;
            prev_abort = abort;
            prev_data  = o_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input string name);
        start = 1'b1; tick(); start = 1'b0;
        chk({name, "_capture"}, 32'(o_state), 32'd1);
        tick();
        chk({name, "_full"}, 32'(o_state), 32'd2);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!o_done && n < budget) begin tick(); n++; end
        chk({name, "_done_seen"}, 32'(o_done), 32'd1);
    endtask

    task automatic go_fetch(input int a, input string name);
        int n = 0;
        while (!(o_state == 3'd3 && o_addr == 4'(a)) && n < 100) begin tick(); n++; end
        chk({name, "_fetch_state"}, 32'(o_state), 32'd3);
        chk({name, "_fetch_addr"}, 32'(o_addr), 32'(a));
    endtask

    task automatic check_words(input string name);
        chk({name, "_count"}, 32'(hs_q.size()), 32'd16);
        for (int i = 0; i < hs_q.size(); i++) chk({name, "_word"}, 32'(hs_q[i]), 32'(i * 16'h0101));
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; dump = 1'b0; abort = 1'b0; full = 1'b0; ready = 1'b0;
        tick(); tick();
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_outs", {o_run_log, o_read_log, o_valid, o_done, o_busy, o_timeout}, 32'd0);
        chk("rst_addr", 32'(o_addr), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        rstn = 1'b1; tick();

        // Capture: full arrives after 20 run cycles
        run_cycles = 0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (19) tick();
        full = 1'b1; tick();
        chk("t2_run_cycles", 32'(run_cycles), 32'd20);
        chk("t2_run_low", 32'(o_run_log), 32'd0);
        chk("t2_state", 32'(o_state), 32'd2);

        // Dump with ready held high
        hs_q.delete(); hs_cyc.delete(); done_cnt = 0;
        ready = 1'b1; dump = 1'b1; tick(); dump = 1'b0;
        wait_done(100, "t3");
        tick();
        check_words("t3");
        for (int i = 1; i < hs_cyc.size(); i++) chk("t3_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);
        chk("t3_idle", 32'(o_state), 32'd0);

        // Dump with random backpressure; full already set -> one-cycle capture
        arm("t4");
        hs_q.delete();
        dump = 1'b1; tick(); dump = 1'b0;
        begin
            int n = 0;
            while (!o_done && n < 400) begin ready = 1'($urandom_range(0, 1)); tick(); n++; end
            chk("t4_done_seen", 32'(o_done), 32'd1);
        end
        ready = 1'b1; tick();
        check_words("t4");

        // Abort in SEND at address 9, then a clean dump from 0
        arm("t5");
        hs_q.delete();
        ready = 1'b1; dump = 1'b1; tick(); dump = 1'b0;
        go_fetch(9, "t5");
        ready = 1'b0; tick();
        chk("t5_valid_pre", 32'(o_valid), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_valid_drop", 32'(o_valid), 32'd0);
        chk("t5_idle", 32'(o_state), 32'd0);
        chk("t5_addr0", 32'(o_addr), 32'd0);
        chk("t5_words_pre", 32'(hs_q.size()), 32'd9);
        arm("t5b");
        hs_q.delete();
        ready = 1'b1; dump = 1'b1; tick(); dump = 1'b0;
        wait_done(100, "t5b");
        tick();
        check_words("t5b");

        // Reset mid-SEND at address 7
        arm("t1");
        dump = 1'b1; tick(); dump = 1'b0;
        go_fetch(7, "t1");
        ready = 1'b0; tick();
        chk("t1_send_addr", 32'(o_addr), 32'd7);
        rstn = 1'b0; tick();
        chk("t1_state", 32'(o_state), 32'd0);
        chk("t1_outs", {o_run_log, o_read_log, o_valid, o_done, o_busy, o_timeout}, 32'd0);
        chk("t1_addr", 32'(o_addr), 32'd0);
        chk("t1_data", 32'(o_data), 32'd0);
        rstn = 1'b1; tick();

        // Capture without full: timeout build or indefinite wait
        full = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (49) tick();
        chk("t6_cap_49", 32'(o_state), 32'd1);
        chk("t6_tmo_49", 32'(o_timeout), 32'd0);
        tick();
`ifdef LOGCTRL_TIMEOUT_EN
        chk("t6_tmo_50", 32'(o_timeout), 32'd1);
        chk("t6_idle_50", 32'(o_state), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("t6_tmo_clear", 32'(o_timeout), 32'd0);
`else
        repeat (150) tick();
        chk("t6_cap_200", 32'(o_state), 32'd1);
        chk("t6_tmo_off", 32'(o_timeout), 32'd0);
`endif
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t6_abort_idle", 32'(o_state), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
